// File: rtl/issue_hazard_scoreboard_if.sv
// Issue-boundary interface for issue_hazard_scoreboard.
// Carries the decoded bundle from the front end and returns the issue decision.
//   squash       : pipeline flush (front end -> scoreboard)
//   id_valid     : per-way valid, contiguous from way 0
//   id_rs1/rs2   : 5-bit source registers, way i at [i*5 +: 5]
//   id_dest      : 5-bit destination register per way (0 = no write)
//   id_lat       : LAT_W-bit producer latency per way
//   issue_count  : number of leading ways issuing this cycle
//   rollback     : valid ways that must be re-presented next cycle
//   busy_regs    : per-register pending-write flags
//   stall_cycles : saturating full-stall cycle counter
interface issue_hazard_scoreboard_if #(
  parameter int WAYS     = 3,
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 3,
  parameter int PERF_W   = 16
);
  localparam int CNT_W = $clog2(WAYS + 1);

  logic                   squash;
  logic [WAYS-1:0]        id_valid;
  logic [WAYS*5-1:0]      id_rs1;
  logic [WAYS*5-1:0]      id_rs2;
  logic [WAYS*5-1:0]      id_dest;
  logic [WAYS*LAT_W-1:0]  id_lat;
  logic [CNT_W-1:0]       issue_count;
  logic [CNT_W-1:0]       rollback;
  logic [NUM_REGS-1:0]    busy_regs;
  logic [PERF_W-1:0]      stall_cycles;

  modport master (
    output squash, id_valid, id_rs1, id_rs2, id_dest, id_lat,
    input  issue_count, rollback, busy_regs, stall_cycles
  );

  modport slave (
    input  squash, id_valid, id_rs1, id_rs2, id_dest, id_lat,
    output issue_count, rollback, busy_regs, stall_cycles
  );
endinterface

// File: rtl/issue_hazard_scoreboard.sv
// N-way issue hazard scoreboard at the ID/issue boundary.
// Tracks a pending-write latency countdown per architectural register and,
// each cycle, reports how many leading ways of the decoded bundle may issue
// in order. Ways that cannot issue are rolled back for re-presentation.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset (clears scoreboard and perf counter)
//   sb    : slave side of issue_hazard_scoreboard_if (bundle in, decision out)
module issue_hazard_scoreboard #(
  parameter int WAYS     = 3,
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 3,
  parameter int MAX_LAT  = 6,
  parameter int PERF_W   = 16
) (
  input logic                      clock,
  input logic                      reset,
  issue_hazard_scoreboard_if.slave sb
);
  localparam int                CNT_W     = $clog2(WAYS + 1);
  localparam logic [LAT_W-1:0]  LAT_CLAMP = LAT_W'(MAX_LAT);

  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic [LAT_W-1:0]    cnt_d [NUM_REGS];
  logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]    valid_cnt, issue_cnt;
  logic [WAYS-1:0]     issue_mask;
  logic [NUM_REGS-1:0] busy;

  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
    return (lat > LAT_CLAMP) ? LAT_CLAMP : lat;
  endfunction

  // ---- issue decision (combinational from scoreboard and bundle) ----
  always_comb begin
    logic       in_prefix;
    logic       stop;
    logic       ok;
    logic [4:0] s1, s2, dj;
    valid_cnt  = '0;
    issue_cnt  = '0;
    issue_mask = '0;
    in_prefix  = 1'b1;
    stop       = 1'b0;
    ok         = 1'b0;
    s1         = '0;
    s2         = '0;
    dj         = '0;
    for (int i = 0; i < WAYS; i++) begin
      s1 = sb.id_rs1[i*5 +: 5];
      s2 = sb.id_rs2[i*5 +: 5];
      ok = ((s1 == 5'd0) || (cnt_q[s1] == '0)) &&
           ((s2 == 5'd0) || (cnt_q[s2] == '0));
      // No same-cycle forwarding: any earlier producer in the bundle blocks.
      for (int j = 0; j < i; j++) begin
        dj = sb.id_dest[j*5 +: 5];
        if ((dj != 5'd0) && ((dj == s1) || (dj == s2)))
          ok = 1'b0;
      end
      // Ways after the first invalid one are ignored entirely.
      if (!sb.id_valid[i])
        in_prefix = 1'b0;
      if (in_prefix) begin
        valid_cnt = valid_cnt + CNT_W'(1);
        if (!stop && ok && !sb.squash) begin
          issue_cnt     = issue_cnt + CNT_W'(1);
          issue_mask[i] = 1'b1;
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

  // ---- scoreboard next state ----
  always_comb begin
    logic [4:0] dk;
    dk = '0;
    for (int r = 0; r < NUM_REGS; r++)
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
    // Ascending order so the highest issued way wins on a shared dest.
    for (int k = 0; k < WAYS; k++) begin
      dk = sb.id_dest[k*5 +: 5];
      if (issue_mask[k] && (dk != 5'd0))
        cnt_d[dk] = clamp_lat(sb.id_lat[k*LAT_W +: LAT_W]);
    end
    cnt_d[0] = '0;
    if (sb.squash) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_d[r] = '0;
    end

    stall_cycles_d = stall_cycles_q;
    if (sb.id_valid[0] && !sb.squash && (issue_cnt == '0) && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
  end

  // ---- state registers ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= cnt_d[r];
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // ---- outputs ----
  always_comb begin
    busy = '0;
    for (int r = 1; r < NUM_REGS; r++)
      busy[r] = (cnt_q[r] != '0);
  end

  assign sb.issue_count  = issue_cnt;
  assign sb.rollback     = valid_cnt - issue_cnt;
  assign sb.busy_regs    = busy;
  assign sb.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_issue_hazard_scoreboard.sv
// Self-checking bench for issue_hazard_scoreboard. The reference model keeps,
// per register, the absolute cycle at which a consumer may first issue.
module tb_issue_hazard_scoreboard;
  localparam int WAYS     = 3;
  localparam int NUM_REGS = 32;
  localparam int LAT_W    = 3;
  localparam int MAX_LAT  = 6;
  localparam int PERF_W   = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  issue_hazard_scoreboard_if #(.WAYS(WAYS), .NUM_REGS(NUM_REGS), .LAT_W(LAT_W),
                               .PERF_W(PERF_W)) ifc ();

  issue_hazard_scoreboard #(.WAYS(WAYS), .NUM_REGS(NUM_REGS), .LAT_W(LAT_W),
                            .MAX_LAT(MAX_LAT), .PERF_W(PERF_W)) dut (
    .clock(clock),
    .reset(reset),
    .sb   (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  // Bundle currently presented.
  int b_valid;
  int b_squash;
  int b_rs1 [WAYS];
  int b_rs2 [WAYS];
  int b_dest[WAYS];
  int b_lat [WAYS];

  // Model: ready_at[r] = first cycle a consumer of r may issue.
  longint ready_at[NUM_REGS];
  longint cyc     = 0;
  int     m_stall = 0;
  bit     chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit src_ok(input int s);
    return (s == 0) || (ready_at[s] <= cyc);
  endfunction

  function automatic int m_issue();
    int ic;
    bit ok;
    ic = 0;
    if (b_squash != 0) return 0;
    for (int i = 0; i < b_valid; i++) begin
      ok = src_ok(b_rs1[i]) && src_ok(b_rs2[i]);
      for (int j = 0; j < i; j++)
        if (b_dest[j] != 0 && (b_dest[j] == b_rs1[i] || b_dest[j] == b_rs2[i]))
          ok = 1'b0;
      if (!ok) break;
      ic++;
    end
    return ic;
  endfunction

  function automatic logic [NUM_REGS-1:0] m_busy();
    logic [NUM_REGS-1:0] b;
    b = '0;
    for (int r = 1; r < NUM_REGS; r++)
      b[r] = (ready_at[r] > cyc);
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) ready_at[r] = 0;
    m_stall = 0;
  endtask

  // Applies the clock edge to the model using the bundle that was presented.
  task automatic model_step();
    int ic;
    int l;
    ic = m_issue();
    if (b_squash != 0) begin
      for (int r = 0; r < NUM_REGS; r++) ready_at[r] = 0;
    end else begin
      for (int k = 0; k < ic; k++) begin
        if (b_dest[k] != 0) begin
          l = (b_lat[k] > MAX_LAT) ? MAX_LAT : b_lat[k];
          ready_at[b_dest[k]] = cyc + 1 + l;
        end
      end
      if (b_valid > 0 && ic == 0 && m_stall < (2**PERF_W - 1)) m_stall++;
    end
    cyc++;
  endtask

  task automatic clear_bundle();
    b_valid  = 0;
    b_squash = 0;
    for (int i = 0; i < WAYS; i++) begin
      b_rs1[i] = 0; b_rs2[i] = 0; b_dest[i] = 0; b_lat[i] = 0;
    end
  endtask

  task automatic set_way(input int i, input int d, input int s1, input int s2, input int l);
    b_dest[i] = d; b_rs1[i] = s1; b_rs2[i] = s2; b_lat[i] = l;
    if (b_valid < i + 1) b_valid = i + 1;
  endtask

  task automatic present();
    ifc.squash = (b_squash != 0);
    for (int i = 0; i < WAYS; i++) begin
      ifc.id_valid[i]              = (i < b_valid);
      ifc.id_rs1[i*5 +: 5]         = 5'(b_rs1[i]);
      ifc.id_rs2[i*5 +: 5]         = 5'(b_rs2[i]);
      ifc.id_dest[i*5 +: 5]        = 5'(b_dest[i]);
      ifc.id_lat[i*LAT_W +: LAT_W] = LAT_W'(b_lat[i]);
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  // Pulses reset between clock edges while the current bundle is held.
  task automatic async_reset_pulse();
    @(posedge clock);
    model_step();
    #3;
    chk_en = 1'b0;
    reset  = 1'b1;
    model_reset();
    #1;
    chk("rst_busy", ifc.busy_regs, '0);
    chk("rst_stall", ifc.stall_cycles, '0);
    reset  = 1'b0;
    #0.1;
    chk_en = 1'b1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    int ic;
    if (chk_en) begin
      ic = m_issue();
      chk("issue_count", ifc.issue_count, ic);
      chk("rollback", ifc.rollback, b_valid - ic);
      chk("busy_regs", ifc.busy_regs, m_busy());
      chk("stall_cycles", ifc.stall_cycles, m_stall);
    end
  end

  initial begin
    clear_bundle();
    model_reset();
    present();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_busy", ifc.busy_regs, '0);
    chk("reset_stall", ifc.stall_cycles, '0);
    chk("reset_issue", ifc.issue_count, '0);
    chk_en = 1'b1;

    // Independent bundle, all issue.
    clear_bundle();
    set_way(0, 1, 2, 3, 0); set_way(1, 4, 5, 6, 0); set_way(2, 7, 8, 9, 0);
    present();
    chk("t1_issue", ifc.issue_count, 3);
    chk("t1_rollback", ifc.rollback, 0);
    tick();
    clear_bundle(); present();
    chk("t1_busy", ifc.busy_regs, '0);

    // Intra-bundle RAW, then re-presentation.
    clear_bundle();
    set_way(0, 1, 2, 3, 0); set_way(1, 4, 1, 5, 0); set_way(2, 6, 7, 8, 0);
    present();
    chk("t2_issue", ifc.issue_count, 1);
    chk("t2_rollback", ifc.rollback, 2);
    tick();
    clear_bundle();
    set_way(0, 4, 1, 5, 0); set_way(1, 6, 7, 8, 0);
    present();
    chk("t2_reissue", ifc.issue_count, 2);
    tick();

    // Load-use with latency 2.
    clear_bundle(); set_way(0, 5, 10, 11, 2); present();
    chk("t3_load", ifc.issue_count, 1);
    tick();
    clear_bundle(); set_way(0, 6, 5, 0, 0); present();
    chk("t3_c1", ifc.issue_count, 0);
    tick(); present();
    chk("t3_c2", ifc.issue_count, 0);
    tick(); present();
    chk("t3_c3", ifc.issue_count, 1);
    chk("t3_stall", ifc.stall_cycles, 2);
    tick();

    // Squash after a latency-3 load.
    clear_bundle(); set_way(0, 5, 0, 0, 3); present();
    tick();
    clear_bundle(); set_way(0, 6, 5, 0, 0); b_squash = 1; present();
    chk("t4_sq_issue", ifc.issue_count, 0);
    chk("t4_sq_rollback", ifc.rollback, 1);
    tick();
    b_squash = 0; present();
    chk("t4_busy", ifc.busy_regs, '0);
    chk("t4_issue", ifc.issue_count, 1);
    chk("t4_stall", ifc.stall_cycles, 2);
    tick();

    // x0 sources/dest and WAW on x9 (lat 1 then lat 4).
    clear_bundle();
    set_way(0, 9, 0, 0, 1); set_way(1, 0, 10, 11, 5); set_way(2, 9, 0, 0, 4);
    present();
    chk("t5_issue", ifc.issue_count, 3);
    tick();
    clear_bundle(); present();
    chk("t5_busy4", ifc.busy_regs, 32'h0000_0200);
    tick(); tick(); tick();
    chk("t5_busy1", ifc.busy_regs, 32'h0000_0200);
    tick();
    chk("t5_busy0", ifc.busy_regs, '0);

    // Asynchronous reset with a pending write and nonzero stall count.
    clear_bundle(); set_way(0, 12, 0, 0, 6); present();
    tick();
    clear_bundle(); present();
    async_reset_pulse();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      clear_bundle();
      b_valid  = $urandom_range(0, WAYS);
      b_squash = ($urandom_range(0, 11) == 0) ? 1 : 0;
      for (int i = 0; i < WAYS; i++) begin
        b_rs1[i]  = $urandom_range(0, 7);
        b_rs2[i]  = $urandom_range(0, 7);
        b_dest[i] = $urandom_range(0, 7);
        b_lat[i]  = $urandom_range(0, 7);
      end
      present();
      if ($urandom_range(0, 199) == 0) begin
        async_reset_pulse();
        @(posedge clock);
        #0.1;
        cyc++;
        // Edge after reset: apply it to the model as a normal step.
        cyc--;
        model_step_fix();
      end else begin
        tick();
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // The edge following a reset pulse was already taken; account for it.
  task automatic model_step_fix();
    model_step();
    #0.9;
  endtask
endmodule
